// File: rtl/mips_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
//
// Shared definitions for the multi-cycle MIPS control unit:
//   - opcode constants for the supported instruction classes
//   - the 4-bit state encoding (codes are visible on the debug 'state' output)
//   - aluOp, aluSrcB and pcSource encodings
//   - op_supported(): whether an opcode is legal for a given build
//
// Opcode constants are 32 bits wide so they compare cleanly against an opcode
// field of any width up to 32 once it has been zero-extended.
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

    // Opcode field values (IR[31:26])
    localparam logic [31:0] OP_RTYPE = 32'd0;
    localparam logic [31:0] OP_J     = 32'd2;
    localparam logic [31:0] OP_BEQ   = 32'd4;
    localparam logic [31:0] OP_ADDI  = 32'd8;
    localparam logic [31:0] OP_LW    = 32'd35;
    localparam logic [31:0] OP_SW    = 32'd43;

    // Controller states; codes 12..15 are unused and recover to FETCH
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_e;

    // ALU operation requested from the ALU control block
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // ALU B-input select
    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // Next-PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // True when the opcode is executable in this build. j and addi are
    // optional; everything outside the table is illegal.
    function automatic logic op_supported(input logic [31:0] op,
                                          input logic        en_jump,
                                          input logic        en_addi);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_RTYPE, OP_BEQ, OP_LW, OP_SW: ok = 1'b1;
            OP_J:                           ok = en_jump;
            OP_ADDI:                        ok = en_addi;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage : mips_ctrl_pkg

// File: rtl/multi_cycle_control_if.sv
// -----------------------------------------------------------------------------
// multi_cycle_control_if
//
// Bundle between the multi-cycle control unit and its datapath.
//   Inputs to the controller : opCode (IR[31:26]), memReady
//   Outputs from controller  : PC/IR/memory/register-file enables, mux selects,
//                              aluOp, illegalOp and instrDone strobes, state
//
// Modports:
//   master - the control unit (drives the enables/selects)
//   slave  - the datapath side (drives opCode and memReady)
// -----------------------------------------------------------------------------
interface multi_cycle_control_if #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2
);
    logic [OPCODE_W-1:0] opCode;
    logic                memReady;

    logic                pcWrite;
    logic                pcWriteCond;
    logic                iorD;
    logic                memRead;
    logic                memWrite;
    logic                irWrite;
    logic                memToReg;
    logic                regDst;
    logic                regWrite;
    logic                aluSrcA;
    logic [1:0]          aluSrcB;
    logic [ALUOP_W-1:0]  aluOp;
    logic [1:0]          pcSource;
    logic                illegalOp;
    logic                instrDone;
    logic [3:0]          state;

    modport master (
        input  opCode, memReady,
        output pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
               memToReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp,
               pcSource, illegalOp, instrDone, state
    );

    modport slave (
        output opCode, memReady,
        input  pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
               memToReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp,
               pcSource, illegalOp, instrDone, state
    );

endinterface : multi_cycle_control_if

// File: rtl/multi_cycle_control_next_state.sv
// -----------------------------------------------------------------------------
// ctrl_next_state
//
// Purely combinational next-state function of the multi-cycle controller.
//   state_i    : current state
//   opCode_i   : instruction opcode, stable from DECODE until back in FETCH
//   memReady_i : memory completes the current access this cycle
//   state_o    : next state
//   opLegal_o  : opCode_i is executable in this build (j/addi optional)
// -----------------------------------------------------------------------------
module ctrl_next_state
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter bit ENABLE_JUMP = 1'b1,
    parameter bit ENABLE_ADDI = 1'b1
) (
    input  state_e              state_i,
    input  logic [OPCODE_W-1:0] opCode_i,
    input  logic                memReady_i,
    output state_e              state_o,
    output logic                opLegal_o
);

    logic [31:0] op_ext;

    assign op_ext    = 32'(opCode_i);
    assign opLegal_o = op_supported(op_ext, ENABLE_JUMP, ENABLE_ADDI);

    always_comb begin
        state_o = S_FETCH;
        case (state_i)
            S_FETCH:     state_o = memReady_i ? S_DECODE : S_FETCH;
            S_DECODE: begin
                // Disabled or unknown opcodes fall through to FETCH
                if (opLegal_o) begin
                    case (op_ext)
                        OP_LW, OP_SW: state_o = S_MEM_ADDR;
                        OP_RTYPE:     state_o = S_R_EXEC;
                        OP_BEQ:       state_o = S_BRANCH;
                        OP_J:         state_o = S_JUMP;
                        OP_ADDI:      state_o = S_ADDI_EXEC;
                        default:      state_o = S_FETCH;
                    endcase
                end
            end
            // Only lw and sw reach MEM_ADDR, so anything but sw is a load
            S_MEM_ADDR:  state_o = (op_ext == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_o = memReady_i ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: state_o = memReady_i ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    state_o = S_R_WB;
            S_ADDI_EXEC: state_o = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB:
                         state_o = S_FETCH;
            default:     state_o = S_FETCH;
        endcase
    end

endmodule : ctrl_next_state

// File: rtl/multi_cycle_control.sv
// -----------------------------------------------------------------------------
// multi_cycle_control
//
// Moore control unit for a multi-cycle MIPS datapath with shared memory and a
// shared ALU. Each instruction takes 3..5 states; memReady stalls FETCH,
// MEM_READ and MEM_WRITE one cycle at a time.
//
// Ports:
//   clk    : clock, all state changes on the rising edge
//   reset  : synchronous, active-high; state returns to FETCH on the next edge
//   bus    : master side of multi_cycle_control_if
//            in : opCode, memReady
//            out: pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
//                 memToReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp,
//                 pcSource, illegalOp, instrDone, state
//
// Outputs are a function of the registered state, except pcWrite/irWrite in
// FETCH (qualified by memReady), instrDone in MEM_WRITE (memReady) and
// illegalOp/instrDone in DECODE (opcode legality).
// -----------------------------------------------------------------------------
module multi_cycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int ALUOP_W     = 2,
    parameter bit ENABLE_JUMP = 1'b1,
    parameter bit ENABLE_ADDI = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    multi_cycle_control_if.master  bus
);

    state_e state_q;
    state_e state_d;
    logic   op_legal;

    ctrl_next_state #(
        .OPCODE_W    (OPCODE_W),
        .ENABLE_JUMP (ENABLE_JUMP),
        .ENABLE_ADDI (ENABLE_ADDI)
    ) u_next_state (
        .state_i    (state_q),
        .opCode_i   (bus.opCode),
        .memReady_i (bus.memReady),
        .state_o    (state_d),
        .opLegal_o  (op_legal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        bus.pcWrite     = 1'b0;
        bus.pcWriteCond = 1'b0;
        bus.iorD        = 1'b0;
        bus.memRead     = 1'b0;
        bus.memWrite    = 1'b0;
        bus.irWrite     = 1'b0;
        bus.memToReg    = 1'b0;
        bus.regDst      = 1'b0;
        bus.regWrite    = 1'b0;
        bus.aluSrcA     = 1'b0;
        bus.aluSrcB     = SRCB_B;
        bus.aluOp       = ALUOP_W'(ALU_ADD);
        bus.pcSource    = PCSRC_ALU;
        bus.illegalOp   = 1'b0;
        bus.instrDone   = 1'b0;
        bus.state       = state_q;

        case (state_q)
            S_FETCH: begin
                // PC+4 and the IR load only commit once memory delivers
                bus.memRead  = 1'b1;
                bus.aluSrcB  = SRCB_FOUR;
                bus.aluOp    = ALUOP_W'(ALU_ADD);
                bus.pcSource = PCSRC_ALU;
                bus.pcWrite  = bus.memReady;
                bus.irWrite  = bus.memReady;
            end
            S_DECODE: begin
                // Speculative branch target PC + (imm << 2) into ALUOut
                bus.aluSrcB   = SRCB_IMM_SH2;
                bus.aluOp     = ALUOP_W'(ALU_ADD);
                bus.illegalOp = ~op_legal;
                bus.instrDone = ~op_legal;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                bus.aluSrcA = 1'b1;
                bus.aluSrcB = SRCB_IMM;
                bus.aluOp   = ALUOP_W'(ALU_ADD);
            end
            S_MEM_READ: begin
                bus.memRead = 1'b1;
                bus.iorD    = 1'b1;
            end
            S_MEM_WB: begin
                bus.regWrite  = 1'b1;
                bus.memToReg  = 1'b1;
                bus.regDst    = 1'b0;
                bus.instrDone = 1'b1;
            end
            S_MEM_WRITE: begin
                bus.memWrite  = 1'b1;
                bus.iorD      = 1'b1;
                bus.instrDone = bus.memReady;
            end
            S_R_EXEC: begin
                bus.aluSrcA = 1'b1;
                bus.aluSrcB = SRCB_B;
                bus.aluOp   = ALUOP_W'(ALU_FUNCT);
            end
            S_R_WB: begin
                bus.regWrite  = 1'b1;
                bus.regDst    = 1'b1;
                bus.memToReg  = 1'b0;
                bus.instrDone = 1'b1;
            end
            S_BRANCH: begin
                // A - B sets the zero flag; the PC takes ALUOut only if zero
                bus.aluSrcA     = 1'b1;
                bus.aluSrcB     = SRCB_B;
                bus.aluOp       = ALUOP_W'(ALU_SUB);
                bus.pcWriteCond = 1'b1;
                bus.pcSource    = PCSRC_ALUOUT;
                bus.instrDone   = 1'b1;
            end
            S_JUMP: begin
                bus.pcWrite   = 1'b1;
                bus.pcSource  = PCSRC_JUMP;
                bus.instrDone = 1'b1;
            end
            S_ADDI_WB: begin
                bus.regWrite  = 1'b1;
                bus.regDst    = 1'b0;
                bus.memToReg  = 1'b0;
                bus.instrDone = 1'b1;
            end
            default: begin
                // Unused codes: all strobes stay at their inactive defaults
            end
        endcase
    end

endmodule : multi_cycle_control

// File: tb/tb_multi_cycle_control.sv
// -----------------------------------------------------------------------------
// tb_multi_cycle_control
//
// Directed bench for multi_cycle_control. Two instances share clk/reset:
//   dut  : ENABLE_JUMP=1, ENABLE_ADDI=1
//   dut2 : ENABLE_JUMP=0, ENABLE_ADDI=0 (held in FETCH except in its own test)
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
//
// Expected control word layout (18 bits, MSB first):
//   pcWrite pcWriteCond iorD memRead memWrite irWrite memToReg regDst regWrite
//   aluSrcA aluSrcB[1:0] aluOp[1:0] pcSource[1:0] illegalOp instrDone
// -----------------------------------------------------------------------------
module tb_multi_cycle_control;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multi_cycle_control_if #(.OPCODE_W(6), .ALUOP_W(2)) bus1 ();
    multi_cycle_control_if #(.OPCODE_W(6), .ALUOP_W(2)) bus2 ();

    multi_cycle_control #(
        .OPCODE_W(6), .ALUOP_W(2), .ENABLE_JUMP(1'b1), .ENABLE_ADDI(1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.master)
    );

    multi_cycle_control #(
        .OPCODE_W(6), .ALUOP_W(2), .ENABLE_JUMP(1'b0), .ENABLE_ADDI(1'b0)
    ) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.master)
    );

    // Hand-written expected control words
    //                                pw pc io mr mw ir mg rd rw sa sb aop ps il dn
    localparam logic [17:0] W_FR    = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
    localparam logic [17:0] W_FS    = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
    localparam logic [17:0] W_DEC   = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
    localparam logic [17:0] W_ILL   = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_1_1;
    localparam logic [17:0] W_MADDR = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [17:0] W_MREAD = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] W_MWB   = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_0_1;
    localparam logic [17:0] W_MWR_R = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_1;
    localparam logic [17:0] W_MWR_S = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] W_REX   = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
    localparam logic [17:0] W_RWB   = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_0_1;
    localparam logic [17:0] W_BR    = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_0_1;
    localparam logic [17:0] W_JMP   = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_0_1;
    localparam logic [17:0] W_AWB   = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_0_1;

    typedef struct packed {
        logic        rst;
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [17:0] w;
    } vec_t;

    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(input logic rst, input logic [5:0] op,
                                input logic rdy, input logic [3:0] st,
                                input logic [17:0] w);
        vec_t v;
        v.rst = rst; v.op = op; v.rdy = rdy; v.st = st; v.w = w;
        return v;
    endfunction

    function automatic logic [21:0] obs1();
        return {bus1.state, bus1.pcWrite, bus1.pcWriteCond, bus1.iorD,
                bus1.memRead, bus1.memWrite, bus1.irWrite, bus1.memToReg,
                bus1.regDst, bus1.regWrite, bus1.aluSrcA, bus1.aluSrcB,
                bus1.aluOp, bus1.pcSource, bus1.illegalOp, bus1.instrDone};
    endfunction

    function automatic logic [21:0] obs2();
        return {bus2.state, bus2.pcWrite, bus2.pcWriteCond, bus2.iorD,
                bus2.memRead, bus2.memWrite, bus2.irWrite, bus2.memToReg,
                bus2.regDst, bus2.regWrite, bus2.aluSrcA, bus2.aluSrcB,
                bus2.aluOp, bus2.pcSource, bus2.illegalOp, bus2.instrDone};
    endfunction

    // Apply one cycle of inputs to dut (dut2 kept stalled in FETCH)
    task automatic drive1(input vec_t v);
        @(negedge clk);
        reset         = v.rst;
        bus1.opCode   = v.op;
        bus1.memReady = v.rdy;
        bus2.memReady = 1'b0;
        #1;
    endtask

    // Apply one cycle of inputs to dut2 (dut kept stalled in FETCH)
    task automatic drive2(input vec_t v);
        @(negedge clk);
        reset         = v.rst;
        bus2.opCode   = v.op;
        bus2.memReady = v.rdy;
        bus1.memReady = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        vec_t v[$];
        logic [21:0] a;
        v.push_back(mk(1'b1, 6'd0, 1'b1, 4'd0, W_FR));
        v.push_back(mk(1'b1, 6'd0, 1'b0, 4'd0, W_FS));
        v.push_back(mk(1'b0, 6'd0, 1'b0, 4'd0, W_FS));
        foreach (v[i]) begin
            drive1(v[i]);
            a = obs1();
            checks++;
            if (a !== {v[i].st, v[i].w}) begin
                errors++;
                $display("FAIL reset[%0d]: got state=%0d ctrl=%05h, expected state=%0d ctrl=%05h",
                         i, a[21:18], a[17:0], v[i].st, v[i].w);
            end
        end
    endtask

    task automatic test_lw();
        vec_t v[$];
        logic [21:0] a;
        v.push_back(mk(1'b0, 6'd35, 1'b1, 4'd0, W_FR));
        v.push_back(mk(1'b0, 6'd35, 1'b1, 4'd1, W_DEC));
        v.push_back(mk(1'b0, 6'd35, 1'b1, 4'd2, W_MADDR));
        v.push_back(mk(1'b0, 6'd35, 1'b1, 4'd3, W_MREAD));
        v.push_back(mk(1'b0, 6'd35, 1'b1, 4'd4, W_MWB));
        v.push_back(mk(1'b0, 6'd35, 1'b0, 4'd0, W_FS));
        foreach (v[i]) begin
            drive1(v[i]);
            a = obs1();
            checks++;
            if (a !== {v[i].st, v[i].w}) begin
                errors++;
                $display("FAIL lw[%0d]: got state=%0d ctrl=%05h, expected state=%0d ctrl=%05h",
                         i, a[21:18], a[17:0], v[i].st, v[i].w);
            end
        end
    endtask

    task automatic test_stall_lw();
        vec_t v[$];
        logic [21:0] a;
        v.push_back(mk(1'b0, 6'd35, 1'b0, 4'd0, W_FS));
        v.push_back(mk(1'b0, 6'd35, 1'b1, 4'd0, W_FR));
        v.push_back(mk(1'b0, 6'd35, 1'b1, 4'd1, W_DEC));
        v.push_back(mk(1'b0, 6'd35, 1'b1, 4'd2, W_MADDR));
        v.push_back(mk(1'b0, 6'd35, 1'b0, 4'd3, W_MREAD));
        v.push_back(mk(1'b0, 6'd35, 1'b1, 4'd3, W_MREAD));
        v.push_back(mk(1'b0, 6'd35, 1'b1, 4'd4, W_MWB));
        v.push_back(mk(1'b0, 6'd35, 1'b0, 4'd0, W_FS));
        foreach (v[i]) begin
            drive1(v[i]);
            a = obs1();
            checks++;
            if (a !== {v[i].st, v[i].w}) begin
                errors++;
                $display("FAIL stall_lw[%0d]: got state=%0d ctrl=%05h, expected state=%0d ctrl=%05h",
                         i, a[21:18], a[17:0], v[i].st, v[i].w);
            end
        end
    endtask

    task automatic test_sw_stall();
        vec_t v[$];
        logic [21:0] a;
        v.push_back(mk(1'b0, 6'd43, 1'b1, 4'd0, W_FR));
        v.push_back(mk(1'b0, 6'd43, 1'b1, 4'd1, W_DEC));
        v.push_back(mk(1'b0, 6'd43, 1'b1, 4'd2, W_MADDR));
        v.push_back(mk(1'b0, 6'd43, 1'b0, 4'd5, W_MWR_S));
        v.push_back(mk(1'b0, 6'd43, 1'b0, 4'd5, W_MWR_S));
        v.push_back(mk(1'b0, 6'd43, 1'b0, 4'd5, W_MWR_S));
        v.push_back(mk(1'b0, 6'd43, 1'b1, 4'd5, W_MWR_R));
        v.push_back(mk(1'b0, 6'd43, 1'b0, 4'd0, W_FS));
        foreach (v[i]) begin
            drive1(v[i]);
            a = obs1();
            checks++;
            if (a !== {v[i].st, v[i].w}) begin
                errors++;
                $display("FAIL sw_stall[%0d]: got state=%0d ctrl=%05h, expected state=%0d ctrl=%05h",
                         i, a[21:18], a[17:0], v[i].st, v[i].w);
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t v[$];
        logic [21:0] a;
        v.push_back(mk(1'b0, 6'd0, 1'b1, 4'd0, W_FR));
        v.push_back(mk(1'b0, 6'd0, 1'b1, 4'd1, W_DEC));
        v.push_back(mk(1'b0, 6'd0, 1'b1, 4'd6, W_REX));
        v.push_back(mk(1'b0, 6'd0, 1'b1, 4'd7, W_RWB));
        v.push_back(mk(1'b0, 6'd4, 1'b1, 4'd0, W_FR));
        v.push_back(mk(1'b0, 6'd4, 1'b1, 4'd1, W_DEC));
        v.push_back(mk(1'b0, 6'd4, 1'b1, 4'd8, W_BR));
        v.push_back(mk(1'b0, 6'd4, 1'b0, 4'd0, W_FS));
        foreach (v[i]) begin
            drive1(v[i]);
            a = obs1();
            checks++;
            if (a !== {v[i].st, v[i].w}) begin
                errors++;
                $display("FAIL r_beq[%0d]: got state=%0d ctrl=%05h, expected state=%0d ctrl=%05h",
                         i, a[21:18], a[17:0], v[i].st, v[i].w);
            end
        end
    endtask

    task automatic test_j_addi();
        vec_t v[$];
        logic [21:0] a;
        v.push_back(mk(1'b0, 6'd2, 1'b1, 4'd0,  W_FR));
        v.push_back(mk(1'b0, 6'd2, 1'b1, 4'd1,  W_DEC));
        v.push_back(mk(1'b0, 6'd2, 1'b1, 4'd9,  W_JMP));
        v.push_back(mk(1'b0, 6'd8, 1'b1, 4'd0,  W_FR));
        v.push_back(mk(1'b0, 6'd8, 1'b1, 4'd1,  W_DEC));
        v.push_back(mk(1'b0, 6'd8, 1'b1, 4'd10, W_MADDR));
        v.push_back(mk(1'b0, 6'd8, 1'b1, 4'd11, W_AWB));
        v.push_back(mk(1'b0, 6'd8, 1'b0, 4'd0,  W_FS));
        foreach (v[i]) begin
            drive1(v[i]);
            a = obs1();
            checks++;
            if (a !== {v[i].st, v[i].w}) begin
                errors++;
                $display("FAIL j_addi[%0d]: got state=%0d ctrl=%05h, expected state=%0d ctrl=%05h",
                         i, a[21:18], a[17:0], v[i].st, v[i].w);
            end
        end
    endtask

    task automatic test_illegal();
        vec_t v[$];
        logic [21:0] a;
        v.push_back(mk(1'b0, 6'd63, 1'b1, 4'd0, W_FR));
        v.push_back(mk(1'b0, 6'd63, 1'b1, 4'd1, W_ILL));
        v.push_back(mk(1'b0, 6'd63, 1'b0, 4'd0, W_FS));
        v.push_back(mk(1'b0, 6'd63, 1'b0, 4'd0, W_FS));
        v.push_back(mk(1'b0, 6'd1,  1'b1, 4'd0, W_FR));
        v.push_back(mk(1'b0, 6'd1,  1'b1, 4'd1, W_ILL));
        v.push_back(mk(1'b0, 6'd1,  1'b0, 4'd0, W_FS));
        foreach (v[i]) begin
            drive1(v[i]);
            a = obs1();
            checks++;
            if (a !== {v[i].st, v[i].w}) begin
                errors++;
                $display("FAIL illegal[%0d]: got state=%0d ctrl=%05h, expected state=%0d ctrl=%05h",
                         i, a[21:18], a[17:0], v[i].st, v[i].w);
            end
        end
    endtask

    task automatic test_jump_disabled();
        vec_t v[$];
        logic [21:0] a;
        v.push_back(mk(1'b0, 6'd2, 1'b1, 4'd0, W_FR));
        v.push_back(mk(1'b0, 6'd2, 1'b1, 4'd1, W_ILL));
        v.push_back(mk(1'b0, 6'd2, 1'b0, 4'd0, W_FS));
        v.push_back(mk(1'b0, 6'd8, 1'b1, 4'd0, W_FR));
        v.push_back(mk(1'b0, 6'd8, 1'b1, 4'd1, W_ILL));
        v.push_back(mk(1'b0, 6'd0, 1'b1, 4'd0, W_FR));
        v.push_back(mk(1'b0, 6'd0, 1'b1, 4'd1, W_DEC));
        v.push_back(mk(1'b0, 6'd0, 1'b1, 4'd6, W_REX));
        v.push_back(mk(1'b0, 6'd0, 1'b1, 4'd7, W_RWB));
        v.push_back(mk(1'b0, 6'd0, 1'b0, 4'd0, W_FS));
        foreach (v[i]) begin
            drive2(v[i]);
            a = obs2();
            checks++;
            if (a !== {v[i].st, v[i].w}) begin
                errors++;
                $display("FAIL jump_disabled[%0d]: got state=%0d ctrl=%05h, expected state=%0d ctrl=%05h",
                         i, a[21:18], a[17:0], v[i].st, v[i].w);
            end
        end
    endtask

    task automatic test_reset_mid();
        vec_t v[$];
        logic [21:0] a;
        v.push_back(mk(1'b0, 6'd35, 1'b1, 4'd0, W_FR));
        v.push_back(mk(1'b0, 6'd35, 1'b1, 4'd1, W_DEC));
        v.push_back(mk(1'b0, 6'd35, 1'b1, 4'd2, W_MADDR));
        v.push_back(mk(1'b1, 6'd35, 1'b1, 4'd3, W_MREAD));
        v.push_back(mk(1'b0, 6'd35, 1'b0, 4'd0, W_FS));
        v.push_back(mk(1'b0, 6'd35, 1'b0, 4'd0, W_FS));
        foreach (v[i]) begin
            drive1(v[i]);
            a = obs1();
            checks++;
            if (a !== {v[i].st, v[i].w}) begin
                errors++;
                $display("FAIL reset_mid[%0d]: got state=%0d ctrl=%05h, expected state=%0d ctrl=%05h",
                         i, a[21:18], a[17:0], v[i].st, v[i].w);
            end
        end
    endtask

    initial begin
        bus1.opCode   = 6'd0;
        bus1.memReady = 1'b0;
        bus2.opCode   = 6'd0;
        bus2.memReady = 1'b0;
        reset         = 1'b1;
        repeat (2) @(posedge clk);

        test_reset();
        test_lw();
        test_stall_lw();
        test_sw_stall();
        test_back_to_back();
        test_j_addi();
        test_illegal();
        test_jump_disabled();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_multi_cycle_control
